audio_uart_packer: RTL

AUDIO_UART_PACKER -- requirements
Module: audio_uart_packer

---
 rtl/audio_uart_packer.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_uart_packer.sv
// ---------------------------------------------------------------------------
// audio_uart_packer
//
// Buffers stereo audio samples in a small FIFO and serialises each sample as
// a framed packet of bytes for a downstream UART transmitter.
//
// Packet formats (byte order on the wire):
//   stereo    : SYNC_BYTE, seq, L[7:0], L[15:8], R[7:0], R[15:8], chk
//   left-only : SYNC_BYTE, seq, L[7:0], L[15:8], chk
// chk is the XOR of every byte between SYNC_BYTE and chk. seq counts completed
// packets and wraps 255 -> 0.
//
// Byte pacing: each byte is issued as a one-cycle tx_dv strobe, followed by
// one mandatory gap cycle, then the packer waits for tx_busy to drop before
// the next byte. Consecutive strobes are therefore at least 3 cycles apart.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   audio_ready  one-cycle strobe, audio_left/audio_right valid this cycle
//   audio_left   left sample, two's complement
//   audio_right  right sample, two's complement
//   left_only    1 = short left-only packets (sampled at packet start)
//   tx_busy      downstream UART busy
//   tx_dv        one-cycle strobe, tx_byte valid (registered)
//   tx_byte      byte to the UART (registered)
//   fifo_level   number of samples stored in the FIFO
//   drop_count   samples dropped because the FIFO was full, saturates at 255
//   pkt_active   high from the first byte issue through the last byte issue
// ---------------------------------------------------------------------------
module audio_uart_packer #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            audio_ready,
    input  logic [15:0]                     audio_left,
    input  logic [15:0]                     audio_right,
    input  logic                            left_only,
    input  logic                            tx_busy,
    output logic                            tx_dv,
    output logic [7:0]                      tx_byte,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [7:0]                      drop_count,
    output logic                            pkt_active
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] CNT_ONE   = LW'(1);
    localparam logic [LW-1:0] CNT_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] CNT_EMPTY = LW'(0);

    // Index of the checksum byte, i.e. the last byte of each packet format.
    localparam logic [2:0] LAST_IDX_STEREO = 3'd6;
    localparam logic [2:0] LAST_IDX_LEFT   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Packet helpers. Stored sample layout is {right[15:0], left[15:0]}.
    // -----------------------------------------------------------------------
    function automatic logic [7:0] pkt_checksum(
        input logic [7:0]  seq,
        input logic [31:0] data,
        input logic        lo
    );
        logic [7:0] chk;
        chk = seq ^ data[7:0] ^ data[15:8];
        if (!lo) begin
            chk = chk ^ data[23:16] ^ data[31:24];
        end
        return chk;
    endfunction

    function automatic logic [7:0] pkt_byte(
        input logic [2:0]  idx,
        input logic [7:0]  seq,
        input logic [31:0] data,
        input logic        lo
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = seq;
            3'd2:    b = data[7:0];
            3'd3:    b = data[15:8];
            3'd4:    b = lo ? pkt_checksum(seq, data, lo) : data[23:16];
            3'd5:    b = data[31:24];
            3'd6:    b = pkt_checksum(seq, data, lo);
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [LW-1:0]  count_r;
    logic [7:0]     drop_r;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [31:0]    pkt_data_r;
    logic           pkt_lo_r;
    logic [2:0]     idx_r;
    logic [2:0]     idx_nxt_s;
    logic [7:0]     seq_r;

    logic           tx_dv_r;
    logic [7:0]     tx_byte_r;
    logic           pkt_active_r;

    logic           full_s;
    logic           empty_s;
    logic           pop_s;
    logic           push_s;
    logic           drop_s;
    logic           pkt_done_s;
    logic [2:0]     last_idx_s;
    logic           tx_dv_nxt_s;
    logic [7:0]     tx_byte_nxt_s;
    logic           pkt_active_nxt_s;

    assign full_s     = (count_r == CNT_FULL);
    assign empty_s    = (count_r == CNT_EMPTY);
    assign last_idx_s = pkt_lo_r ? LAST_IDX_LEFT : LAST_IDX_STEREO;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when the packer pulls the head sample at that moment.
    assign push_s = audio_ready && (!full_s || pop_s);
    assign drop_s = audio_ready && full_s && !pop_s;

    // Next-state, byte selection and registered-output preparation.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        pop_s         = 1'b0;
        pkt_done_s    = 1'b0;
        tx_dv_nxt_s   = 1'b0;
        tx_byte_nxt_s = 8'h00;

        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    // The first byte is always the sync marker, so it does not
                    // depend on the sample being loaded in this same cycle.
                    pop_s         = 1'b1;
                    idx_nxt_s     = 3'd0;
                    state_nxt_s   = ST_ISSUE;
                    tx_dv_nxt_s   = 1'b1;
                    tx_byte_nxt_s = SYNC_BYTE;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_GAP;
            end
            ST_GAP: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!tx_busy) begin
                    if (idx_r == last_idx_s) begin
                        pkt_done_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        idx_nxt_s     = idx_r + 3'd1;
                        state_nxt_s   = ST_ISSUE;
                        tx_dv_nxt_s   = 1'b1;
                        tx_byte_nxt_s = pkt_byte(idx_r + 3'd1, seq_r, pkt_data_r, pkt_lo_r);
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // pkt_active covers every cycle from the first strobe through the final
    // strobe; it drops once the checksum byte has been issued.
    always_comb begin
        pkt_active_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_ISSUE: pkt_active_nxt_s = 1'b1;
            ST_GAP:   pkt_active_nxt_s = (idx_nxt_s != last_idx_s);
            ST_WAIT:  pkt_active_nxt_s = (idx_nxt_s != last_idx_s);
            ST_IDLE:  pkt_active_nxt_s = 1'b0;
            default:  pkt_active_nxt_s = 1'b0;
        endcase
    end

    // Sample storage; contents are don't-care until written, pointers gate use.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {audio_right, audio_left};
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            drop_r   <= 8'h00;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

    // Packet FSM, packet register, sequence number and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            pkt_data_r   <= 32'h0000_0000;
            pkt_lo_r     <= 1'b0;
            idx_r        <= 3'd0;
            seq_r        <= 8'h00;
            tx_dv_r      <= 1'b0;
            tx_byte_r    <= 8'h00;
            pkt_active_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            idx_r        <= idx_nxt_s;
            tx_dv_r      <= tx_dv_nxt_s;
            tx_byte_r    <= tx_byte_nxt_s;
            pkt_active_r <= pkt_active_nxt_s;
            if (pop_s) begin
                // Mode is frozen here so mid-packet changes wait for the next packet.
                pkt_data_r <= mem_r[rd_ptr_r];
                pkt_lo_r   <= left_only;
            end
            if (pkt_done_s) begin
                seq_r <= seq_r + 8'd1;
            end
        end
    end

    assign tx_dv      = tx_dv_r;
    assign tx_byte    = tx_byte_r;
    assign fifo_level = count_r;
    assign drop_count = drop_r;
    assign pkt_active = pkt_active_r;

endmodule
